// File: rtl/dir_input_queue_pkg.sv
// Shared snake-game definitions: direction encoding, PS/2 set-2 scan codes
// and direction helpers. The snake engine imports the same constants.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  // Prefix bytes
  localparam logic [7:0] SC_E0 = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_F0 = 8'hF0;  // break (release) prefix

  // WASD make codes
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_A = 8'h1C;

  // Arrow make codes (always follow an E0 prefix)
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  // Up<->down and left<->right differ only in the top bit of the encoding.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_input_queue_if.sv
// Keyboard-to-engine direction bus: scan-code stream and movement tick in,
// queued direction plus status out.
interface dir_input_queue_if;
  import snake_pkg::*;

  logic [7:0] scan_code;
  logic       scan_valid;
  logic       step;
  dir_t       dir;
  dir_t       cur_dir;
  logic [2:0] queue_count;
  logic       turn_accepted;
  logic       turn_dropped;

  // Driver side: PS/2 receiver and movement timer, observing the queue.
  modport master (
    output scan_code, scan_valid, step,
    input  dir, cur_dir, queue_count, turn_accepted, turn_dropped
  );

  // The direction queue itself.
  modport slave (
    input  scan_code, scan_valid, step,
    output dir, cur_dir, queue_count, turn_accepted, turn_dropped
  );

endinterface

// File: rtl/dir_input_queue_ps2_key_decoder.sv
// PS/2 prefix tracker: follows E0/F0 prefixes and flags make codes of the
// four arrow keys and W/A/S/D as a direction turn in the strobe cycle.
module ps2_key_decoder
  import snake_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       turn_valid,
  output dir_t       turn_dir
);

  dec_state_t state;

  // Prefix state advances only on a valid byte; any byte after a break
  // prefix is the released key and is swallowed.
  // NOTE: clocked state uses <= so every register samples pre-edge values;
  // blocking assignments here would create order-dependent simulation.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state <= DEC_IDLE;
    end else if (scan_valid) begin
      case (state)
        DEC_IDLE: begin
          if (scan_code == SC_E0)      state <= DEC_EXT;
          else if (scan_code == SC_F0) state <= DEC_BRK;
        end
        DEC_EXT:  state <= (scan_code == SC_F0) ? DEC_EXT_BRK : DEC_IDLE;
        default:  state <= DEC_IDLE;
      endcase
    end
  end

  // Turn is flagged in the same cycle as the final byte so the queue can
  // register it on the next edge, giving one-cycle key-to-dir latency.
  // NOTE: every output gets a default first; a missed branch in always_comb
  // would otherwise infer a latch.
  always_comb begin
    turn_valid = 1'b0;
    turn_dir   = DIR_UP;
    if (scan_valid) begin
      case (state)
        DEC_IDLE: begin
          case (scan_code)
            SC_W:    begin turn_valid = 1'b1; turn_dir = DIR_UP;    end
            SC_D:    begin turn_valid = 1'b1; turn_dir = DIR_RIGHT; end
            SC_S:    begin turn_valid = 1'b1; turn_dir = DIR_DOWN;  end
            SC_A:    begin turn_valid = 1'b1; turn_dir = DIR_LEFT;  end
            default: ;
          endcase
        end
        DEC_EXT: begin
          case (scan_code)
            SC_ARROW_UP:    begin turn_valid = 1'b1; turn_dir = DIR_UP;    end
            SC_ARROW_RIGHT: begin turn_valid = 1'b1; turn_dir = DIR_RIGHT; end
            SC_ARROW_DOWN:  begin turn_valid = 1'b1; turn_dir = DIR_DOWN;  end
            SC_ARROW_LEFT:  begin turn_valid = 1'b1; turn_dir = DIR_LEFT;  end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dir_input_queue.sv
// Direction input queue: decodes keypresses into turns, filters reversals
// and duplicates against the newest pending direction, buffers up to DEPTH
// turns and commits one per movement step.
module dir_input_queue
  import snake_pkg::*;
#(
  parameter int   DEPTH    = 2,          // pending-turn entries, 2..4
  parameter dir_t INIT_DIR = DIR_RIGHT
) (
  input logic             CLOCK_50,
  input logic             rst,
  dir_input_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  logic       turn_valid;
  dir_t       turn_dir;

  dir_t       fifo_mem [DEPTH];
  ptr_t       rd_ptr;
  ptr_t       wr_ptr;
  logic [2:0] count;
  dir_t       cur_dir_q;
  logic       turn_accepted_q;
  logic       turn_dropped_q;

  logic       empty;
  logic       full;
  ptr_t       tail_ptr;
  dir_t       ref_dir;
  logic       do_pop;
  logic       do_push;
  logic       do_drop;

  ps2_key_decoder u_decoder (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .scan_code  (bus.scan_code),
    .scan_valid (bus.scan_valid),
    .turn_valid (turn_valid),
    .turn_dir   (turn_dir)
  );

  // Accept/drop decision. The reference is the newest pending turn (or the
  // committed direction when nothing is pending), taken before any pop in
  // this cycle. A full queue still accepts when step frees a slot.
  always_comb begin
    empty    = (count == 3'd0);
    full     = (count == 3'(DEPTH));
    tail_ptr = (wr_ptr == '0) ? ptr_t'(DEPTH - 1) : ptr_t'(wr_ptr - 1'b1);
    ref_dir  = empty ? cur_dir_q : fifo_mem[tail_ptr];
    do_pop   = bus.step && !empty;
    do_push  = 1'b0;
    do_drop  = 1'b0;
    if (turn_valid) begin
      if ((turn_dir == ref_dir) || (turn_dir == opposite(ref_dir)) ||
          (full && !bus.step)) begin
        do_drop = 1'b1;
      end else begin
        do_push = 1'b1;
      end
    end
  end

  // Queue control, committed direction and status pulses.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= 3'd0;
      cur_dir_q       <= INIT_DIR;
      turn_accepted_q <= 1'b0;
      turn_dropped_q  <= 1'b0;
    end else begin
      turn_accepted_q <= do_push;
      turn_dropped_q  <= do_drop;
      if (do_pop) begin
        cur_dir_q <= fifo_mem[rd_ptr];
        rd_ptr    <= ptr_inc(rd_ptr);
      end
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Turn storage; entries are only read while count says they are valid.
  // NOTE: storage arrays are deliberately left out of reset; the pointers
  // and count gate every read, and an unreset array maps to plain flops/RAM.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= turn_dir;
    end
  end

  assign bus.dir           = empty ? cur_dir_q : fifo_mem[rd_ptr];
  assign bus.cur_dir       = cur_dir_q;
  assign bus.queue_count   = count;
  assign bus.turn_accepted = turn_accepted_q;
  assign bus.turn_dropped  = turn_dropped_q;

endmodule
